// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register for the OTTER pipelined core.
// Captures decoded operands/control each cycle, holds on stall, inserts a
// side-effect-free bubble on flush, and counts inserted bubbles for debug.
module id_ex_pipe_reg #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              StallE,
   input  logic              FlushE,
   input  logic              ValidD,
   input  logic [XLEN-1:0]   PCD,
   input  logic [XLEN-1:0]   RD1D,
   input  logic [XLEN-1:0]   RD2D,
   input  logic [XLEN-1:0]   ImmD,
   input  logic [4:0]        Rs1D,
   input  logic [4:0]        Rs2D,
   input  logic [4:0]        RdD,
   input  logic [3:0]        ALUFunD,
   input  logic              ALUSrcD,
   input  logic              RegWriteD,
   input  logic              MemWriteD,
   input  logic              MemReadD,
   input  logic              JumpD,
   input  logic              BranchD,
   input  logic [1:0]        ResultSrcD,
   output logic [XLEN-1:0]   PCE,
   output logic [XLEN-1:0]   RD1E,
   output logic [XLEN-1:0]   RD2E,
   output logic [XLEN-1:0]   ImmE,
   output logic [4:0]        Rs1E,
   output logic [4:0]        Rs2E,
   output logic [4:0]        RdE,
   output logic [3:0]        ALUFunE,
   output logic              ALUSrcE,
   output logic              RegWriteE,
   output logic              MemWriteE,
   output logic              MemReadE,
   output logic              JumpE,
   output logic              BranchE,
   output logic [1:0]        ResultSrcE,
   output logic              ValidE,
   output logic [CNT_W-1:0]  BubbleCnt
);

   localparam int unsigned REG_AW = 5;
   localparam int unsigned FUN_W  = 4;
   localparam int unsigned RSRC_W = 2;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic [FUN_W-1:0]  alu_fun;
      logic              alu_src;
      logic              reg_write;
      logic              mem_write;
      logic              mem_read;
      logic              jump;
      logic              branch;
      logic [RSRC_W-1:0] result_src;
      logic              valid;
   } stage_t;

   stage_t           stage_q, stage_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Next-stage selection: flush beats stall, stall holds, else capture.
   always_comb begin
      stage_d      = stage_q;
      bubble_cnt_d = bubble_cnt_q;
      if (FlushE) begin
         stage_d      = '0;
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end else if (!StallE) begin
         stage_d.pc         = PCD;
         stage_d.rd1        = RD1D;
         stage_d.rd2        = RD2D;
         stage_d.imm        = ImmD;
         stage_d.rs1        = Rs1D;
         stage_d.rs2        = Rs2D;
         stage_d.rd         = RdD;
         stage_d.alu_fun    = ALUFunD;
         stage_d.alu_src    = ALUSrcD;
         stage_d.result_src = ResultSrcD;
         stage_d.valid      = ValidD;
         // An invalid slot must never write registers/memory or redirect fetch.
         stage_d.reg_write  = RegWriteD & ValidD;
         stage_d.mem_write  = MemWriteD & ValidD;
         stage_d.mem_read   = MemReadD  & ValidD;
         stage_d.jump       = JumpD     & ValidD;
         stage_d.branch     = BranchD   & ValidD;
      end
   end

   // Stage and bubble-counter registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stage_q      <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stage_q      <= stage_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign PCE        = stage_q.pc;
   assign RD1E       = stage_q.rd1;
   assign RD2E       = stage_q.rd2;
   assign ImmE       = stage_q.imm;
   assign Rs1E       = stage_q.rs1;
   assign Rs2E       = stage_q.rs2;
   assign RdE        = stage_q.rd;
   assign ALUFunE    = stage_q.alu_fun;
   assign ALUSrcE    = stage_q.alu_src;
   assign RegWriteE  = stage_q.reg_write;
   assign MemWriteE  = stage_q.mem_write;
   assign MemReadE   = stage_q.mem_read;
   assign JumpE      = stage_q.jump;
   assign BranchE    = stage_q.branch;
   assign ResultSrcE = stage_q.result_src;
   assign ValidE     = stage_q.valid;
   assign BubbleCnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: each driven cycle pushes the expected
// E-stage image; an independent monitor pops and compares after every edge.
module tb_id_ex_pipe_reg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 4;

   logic CLK = 1'b0;
   logic RST_N = 1'b1;
   logic StallE = 1'b0, FlushE = 1'b0, ValidD = 1'b0;
   logic [XLEN-1:0] PCD = '0, RD1D = '0, RD2D = '0, ImmD = '0;
   logic [4:0] Rs1D = '0, Rs2D = '0, RdD = '0;
   logic [3:0] ALUFunD = '0;
   logic ALUSrcD = 1'b0, RegWriteD = 1'b0, MemWriteD = 1'b0, MemReadD = 1'b0;
   logic JumpD = 1'b0, BranchD = 1'b0;
   logic [1:0] ResultSrcD = '0;

   logic [XLEN-1:0] PCE, RD1E, RD2E, ImmE;
   logic [4:0] Rs1E, Rs2E, RdE;
   logic [3:0] ALUFunE;
   logic ALUSrcE, RegWriteE, MemWriteE, MemReadE, JumpE, BranchE, ValidE;
   logic [1:0] ResultSrcE;
   logic [CNT_W-1:0] BubbleCnt;

   id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST_N(RST_N), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
      .PCD(PCD), .RD1D(RD1D), .RD2D(RD2D), .ImmD(ImmD),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUFunD(ALUFunD), .ALUSrcD(ALUSrcD),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemReadD(MemReadD),
      .JumpD(JumpD), .BranchD(BranchD), .ResultSrcD(ResultSrcD),
      .PCE(PCE), .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ALUFunE(ALUFunE), .ALUSrcE(ALUSrcE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
      .JumpE(JumpE), .BranchE(BranchE), .ResultSrcE(ResultSrcE),
      .ValidE(ValidE), .BubbleCnt(BubbleCnt)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [XLEN-1:0] pc, rd1, rd2, imm;
      logic [4:0] rs1, rs2, rd;
      logic [3:0] fun;
      logic alusrc, regw, memw, memr, jump, br;
      logic [1:0] rsrc;
      logic valid;
      logic [CNT_W-1:0] cnt;
   } e_t;

   e_t m;
   e_t q[$];
   int checks = 0;
   int failures = 0;

   function automatic e_t dut_out();
      e_t o;
      o.pc = PCE; o.rd1 = RD1E; o.rd2 = RD2E; o.imm = ImmE;
      o.rs1 = Rs1E; o.rs2 = Rs2E; o.rd = RdE; o.fun = ALUFunE;
      o.alusrc = ALUSrcE; o.regw = RegWriteE; o.memw = MemWriteE;
      o.memr = MemReadE; o.jump = JumpE; o.br = BranchE;
      o.rsrc = ResultSrcE; o.valid = ValidE; o.cnt = BubbleCnt;
      return o;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected behaviour of one clock edge, from the current D-side inputs.
   task automatic step();
      e_t n;
      n = m;
      if (FlushE) begin
         n = '0;
         n.cnt = m.cnt + 4'd1;
      end else if (!StallE) begin
         n.pc = PCD; n.rd1 = RD1D; n.rd2 = RD2D; n.imm = ImmD;
         n.rs1 = Rs1D; n.rs2 = Rs2D; n.rd = RdD; n.fun = ALUFunD;
         n.alusrc = ALUSrcD; n.rsrc = ResultSrcD; n.valid = ValidD;
         n.regw = ValidD ? RegWriteD : 1'b0;
         n.memw = ValidD ? MemWriteD : 1'b0;
         n.memr = ValidD ? MemReadD  : 1'b0;
         n.jump = ValidD ? JumpD     : 1'b0;
         n.br   = ValidD ? BranchD   : 1'b0;
      end
      m = n;
      q.push_back(n);
      @(posedge CLK);
      #2;
   endtask

   task automatic rand_inputs();
      PCD = $urandom; RD1D = $urandom; RD2D = $urandom; ImmD = $urandom;
      Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
      ALUFunD = 4'($urandom); ALUSrcD = 1'($urandom);
      RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); MemReadD = 1'($urandom);
      JumpD = 1'($urandom); BranchD = 1'($urandom); ResultSrcD = 2'($urandom);
      ValidD = 1'($urandom);
   endtask

   // Monitor: one expected image per clock edge while the driver is active.
   initial begin : monitor
      e_t e, a;
      forever begin
         @(posedge CLK);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            a = dut_out();
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL scoreboard t=%0t actual=%h required=%h", $time, a, e);
            end
         end
      end
   end

   // Directed stimulus.
   initial begin : driver
      m = '0;
      #1 RST_N = 1'b0;
      #1 check("reset_initial", 64'(dut_out() != '0), 64'd0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #2;

      // Pass-through.
      ValidD = 1'b1; PCD = 32'h0000_0100; RD2D = 32'h0000_0005; ImmD = 32'hFFFF_FFFC;
      ALUSrcD = 1'b1; RegWriteD = 1'b1; RdD = 5'd5;
      step();
      check("pass_pce", 64'(PCE), 64'h100);
      check("pass_imme", 64'(ImmE), 64'hFFFF_FFFC);
      check("pass_rd2e", 64'(RD2E), 64'h5);
      check("pass_alusrc", 64'(ALUSrcE), 64'd1);
      check("pass_regwrite", 64'(RegWriteE), 64'd1);
      check("pass_rde", 64'(RdE), 64'd5);
      check("pass_valid", 64'(ValidE), 64'd1);

      // Stall hold across three cycles.
      PCD = 32'h200;
      step();
      StallE = 1'b1;
      PCD = 32'h204; step();
      check("stall1_pce", 64'(PCE), 64'h200);
      PCD = 32'h208; step();
      check("stall2_pce", 64'(PCE), 64'h200);
      PCD = 32'h20C; step();
      check("stall3_pce", 64'(PCE), 64'h200);
      check("stall3_valid", 64'(ValidE), 64'd1);
      StallE = 1'b0;
      step();
      check("release_pce", 64'(PCE), 64'h20C);

      // Flush beats stall, and counts.
      RegWriteD = 1'b1; MemWriteD = 1'b1; ALUSrcD = 1'b1;
      step();
      check("prio_pre_memw", 64'(MemWriteE), 64'd1);
      FlushE = 1'b1; StallE = 1'b1;
      step();
      check("prio_valid", 64'(ValidE), 64'd0);
      check("prio_regw", 64'(RegWriteE), 64'd0);
      check("prio_memw", 64'(MemWriteE), 64'd0);
      check("prio_alusrc", 64'(ALUSrcE), 64'd0);
      check("prio_cnt", 64'(BubbleCnt), 64'd1);
      StallE = 1'b0;
      step(); step();
      check("flush3_cnt", 64'(BubbleCnt), 64'd3);
      FlushE = 1'b0;

      // Invalid capture suppresses control but keeps data.
      ValidD = 1'b0; RegWriteD = 1'b1; MemWriteD = 1'b1; RD1D = 32'hDEAD_BEEF;
      step();
      check("inv_valid", 64'(ValidE), 64'd0);
      check("inv_regw", 64'(RegWriteE), 64'd0);
      check("inv_memw", 64'(MemWriteE), 64'd0);
      check("inv_rd1e", 64'(RD1E), 64'hDEAD_BEEF);
      check("inv_cnt_held", 64'(BubbleCnt), 64'd3);

      // Mixed traffic through the scoreboard.
      for (int i = 0; i < 40; i++) begin
         rand_inputs();
         StallE = ($urandom_range(0, 3) == 0);
         FlushE = ($urandom_range(0, 4) == 0);
         step();
      end
      StallE = 1'b0; FlushE = 1'b0;

      // Mid-operation reset between edges, observed before the next edge.
      rand_inputs(); ValidD = 1'b1;
      step();
      RST_N = 1'b0;
      #1 check("midreset_zero", 64'(dut_out() != '0), 64'd0);
      check("midreset_cnt", 64'(BubbleCnt), 64'd0);
      #1 RST_N = 1'b1;
      m = '0;

      // Counter wrap with a 4-bit counter.
      FlushE = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         step();
         if (i == 15) check("wrap_15", 64'(BubbleCnt), 64'd15);
         if (i == 16) check("wrap_0", 64'(BubbleCnt), 64'd0);
         if (i == 17) check("wrap_1", 64'(BubbleCnt), 64'd1);
      end
      FlushE = 1'b0;

      // Drain: bounded wait for the monitor to consume everything.
      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge CLK);
      #2;
      check("scoreboard_drained", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
